lfsr_gen: RTL and testbench

Parametrised Galois LFSR pseudo-random source with a valid/ready output. It replaces the fixed 4-bit, free-running generator. It adds runtime seed load, enable gating, all-zero lockup recovery and period-wrap detection. It feeds test-pattern and randomised-stall logic in the NPC, and advances only when a consumer accepts a word.

---
 rtl/lfsr_pkg.sv | 31 +++
 rtl/lfsr_step.sv | 23 ++
 rtl/lfsr_gen.sv | 125 ++++++++++++
 tb/tb_lfsr_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the Galois LFSR generator family.
// The tap masks follow the lfsr_step convention: bit i set means the MSB
// is XORed into bit i on every step. Bit 0 always receives the MSB.
package lfsr_pkg;

    // Smallest state width that still forms a meaningful shift register.
    localparam int unsigned LFSR_MIN_WIDTH = 2;

    // 4-bit default: x^4+x^2+x+1, a short period-7 cycle from 4'b1111.
    localparam logic [3:0]  DEF_POLY_4  = 4'b0110;
    localparam logic [3:0]  DEF_SEED_4  = 4'b1111;

    // 8-bit default: x^8+x^4+x^3+x^2+1, maximal length (255).
    localparam logic [7:0]  DEF_POLY_8  = 8'h1C;
    localparam logic [7:0]  DEF_SEED_8  = 8'h01;

    // 16-bit default: x^16+x^5+x^3+x^2+1.
    localparam logic [15:0] DEF_POLY_16 = 16'h002C;
    localparam logic [15:0] DEF_SEED_16 = 16'h0001;

    // 32-bit default: x^32+x^22+x^2+x+1.
    localparam logic [31:0] DEF_POLY_32 = 32'h0040_0006;
    localparam logic [31:0] DEF_SEED_32 = 32'h0000_0001;

    // An all-zero seed locks the register up forever; used by the
    // elaboration-time seed check.
    function automatic logic seed_is_legal(input logic [63:0] seed);
        return seed != 64'd0;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One Galois LFSR step: purely combinational next-state function.
// Kept separate so a skip-ahead variant can chain several copies.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] POLY  = DEF_POLY_4
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o
);

    // Shift toward the MSB; the MSB wraps into bit 0 and into every tapped bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_o    = '0;
        next_o[0] = state_i[WIDTH-1];
        for (int i = 1; i < int'(WIDTH); i++) begin
            next_o[i] = state_i[i-1] ^ (POLY[i] & state_i[WIDTH-1]);
        end
    end

endmodule

// File: rtl/lfsr_gen.sv
// Galois LFSR pseudo-random source with a valid/ready output port.
// The state advances only when a consumer accepts a word. A runtime seed
// load flushes any pending word, and a zero seed is replaced by SEED.
// wrap_o marks the return to the loaded seed.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] POLY  = DEF_POLY_4,
    parameter logic [WIDTH-1:0] SEED  = DEF_SEED_4,
    parameter int unsigned      OUT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             seed_valid_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic [WIDTH-1:0] state_o,
    output logic [WIDTH-1:0] step_cnt_o,
    output logic             wrap_o,
    output logic             lockup_o
);

    // Reject parameter sets that cannot work before anything is built.
    if (WIDTH < LFSR_MIN_WIDTH) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be at least 2");
    end
    if (!seed_is_legal(64'(SEED))) begin : g_bad_seed
        $error("lfsr_gen: SEED must be non-zero");
    end
    if (OUT_W == 0 || OUT_W > WIDTH) begin : g_bad_out_w
        $error("lfsr_gen: OUT_W must be within 1..WIDTH");
    end

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;

    logic [WIDTH-1:0] step_next;
    logic [WIDTH-1:0] load_val;
    logic             fire;
    logic             seed_zero;

    lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .state_i (state_q),
        .next_o  (step_next)
    );

    assign fire      = valid_q & out_ready_i;
    assign seed_zero = (seed_i == '0);
    // A zero seed would lock the register up, so substitute the reset seed.
    assign load_val  = seed_zero ? SEED : seed_i;

    // State, seed, counter and pulses: a seed load outranks a same-cycle handshake.
    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        if (seed_valid_i) begin
            state_d  = load_val;
            seed_d   = load_val;
            cnt_d    = '0;
            lockup_d = seed_zero;
        end else if (fire) begin
            state_d = step_next;
            if (step_next == seed_q) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    // Valid: a load flushes the word, en_i presents one, a pending word is held until taken.
    always_comb begin
        valid_d = 1'b0;
        if (seed_valid_i) begin
            valid_d = 1'b0;
        end else if (en_i) begin
            valid_d = 1'b1;
        end else if (valid_q && !out_ready_i) begin
            valid_d = 1'b1;
        end
    end

    // Registers, all returning to their reset values asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= SEED;
            seed_q   <= SEED;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q  <= state_d;
            seed_q   <= seed_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign out_valid_o = valid_q;
    assign data_o      = state_q[OUT_W-1:0];
    assign state_o     = state_q;
    assign step_cnt_o  = cnt_q;
    assign wrap_o      = wrap_q;
    assign lockup_o    = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen. A 4-bit default instance covers the
// handshake, seed, lockup, wrap and reset behaviour. Two 8-bit instances
// cover the long sequences. Expected words come from the polynomial model
// in this file and are queued, then popped as the DUT presents them.
module tb_lfsr_gen;

    typedef struct packed {
        logic [3:0] state;
        logic [3:0] cnt;
        logic       wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    // 4-bit default instance
    logic       en, seed_valid, ready;
    logic [3:0] seed;
    logic       valid, wrap, lockup;
    logic [1:0] data;
    logic [3:0] state, cnt;

    // 8-bit instances: a = maximal-length taps, b = taps 8'hB8
    logic       en8;
    logic       zero8_sv = 1'b0;
    logic       one8_rdy = 1'b1;
    logic [7:0] zero8_seed = 8'h00;
    logic       valid8a, wrap8a, lock8a, valid8b, wrap8b, lock8b;
    logic [7:0] data8a, st8a, cnt8a, data8b, st8b, cnt8b;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    lfsr_gen dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .seed_valid_i(seed_valid),
        .seed_i(seed), .out_valid_o(valid), .out_ready_i(ready), .data_o(data),
        .state_o(state), .step_cnt_o(cnt), .wrap_o(wrap), .lockup_o(lockup)
    );

    lfsr_gen #(.WIDTH(8), .POLY(8'h1C), .SEED(8'h01), .OUT_W(8)) dut8a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en8), .seed_valid_i(zero8_sv),
        .seed_i(zero8_seed), .out_valid_o(valid8a), .out_ready_i(one8_rdy), .data_o(data8a),
        .state_o(st8a), .step_cnt_o(cnt8a), .wrap_o(wrap8a), .lockup_o(lock8a)
    );

    lfsr_gen #(.WIDTH(8), .POLY(8'hB8), .SEED(8'h01), .OUT_W(8)) dut8b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en8), .seed_valid_i(zero8_sv),
        .seed_i(zero8_seed), .out_valid_o(valid8b), .out_ready_i(one8_rdy), .data_o(data8b),
        .state_o(st8b), .step_cnt_o(cnt8b), .wrap_o(wrap8b), .lockup_o(lock8b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Multiply-by-x modulo the polynomial x^4 + POLY taps + 1 (default taps 0110).
    function automatic logic [3:0] model4(input logic [3:0] q);
        logic [4:0] t;
        t = {q, 1'b0};
        if (q[3]) t = t ^ 5'b1_0111;
        return t[3:0];
    endfunction

    function automatic logic [7:0] model8(input logic [7:0] q, input logic [7:0] poly);
        logic [8:0] t;
        t = {q, 1'b0};
        if (q[7]) t = t ^ {1'b1, poly[7:1], 1'b1};
        return t[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue n expected words starting at the loaded seed, then pop one per accepted word.
    task automatic run_stream(input logic [3:0] seed_v, input int n);
        exp_t       e;
        logic [3:0] s, s_next, c;
        logic       w;
        int         budget;
        s = seed_v;
        c = '0;
        w = 1'b0;
        for (int k = 0; k < n; k++) begin
            e.state = s; e.cnt = c; e.wrap = w;
            sb_q.push_back(e);
            s_next = model4(s);
            if (s_next == seed_v) begin c = '0; w = 1'b1; end
            else begin c = c + 4'd1; w = 1'b0; end
            s = s_next;
        end
        budget = 4 * n + 4;
        while (sb_q.size() > 0 && budget > 0) begin
            tick();
            budget--;
            if (valid && ready) begin
                e = sb_q.pop_front();
                check_eq("stream_state", 32'(state), 32'(e.state));
                check_eq("stream_data",  32'(data),  32'(e.state[1:0]));
                check_eq("stream_cnt",   32'(cnt),   32'(e.cnt));
                check_eq("stream_wrap",  32'(wrap),  32'(e.wrap));
            end
        end
        check_eq("stream_drained", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_a, exp_b;
        logic [255:0] seen;
        int wrap_at_a, wrap_at_b, period_b, dups, zeros, distinct;

        rst_n = 1'b0; en = 1'b0; ready = 1'b0; seed_valid = 1'b0; seed = '0; en8 = 1'b0;
        #12;
        // Reset state
        check_eq("rst_valid",  32'(valid),  32'd0);
        check_eq("rst_state",  32'(state),  32'hF);
        check_eq("rst_cnt",    32'(cnt),    32'd0);
        check_eq("rst_wrap",   32'(wrap),   32'd0);
        check_eq("rst_lockup", 32'(lockup), 32'd0);
        rst_n = 1'b1;

        // Free run from reset: 1111,1001,0101,1010,0011,0110,1100,1111(wrap)
        en = 1'b1; ready = 1'b1;
        run_stream(4'hF, 8);

        // Last word fires; 1001 is presented and then held with ready low
        tick();
        ready = 1'b0;
        check_eq("hold_enter_state", 32'(state), 32'h9);
        check_eq("hold_enter_cnt",   32'(cnt),   32'd1);
        check_eq("hold_enter_wrap",  32'(wrap),  32'd0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("hold_valid", 32'(valid), 32'd1);
            check_eq("hold_data",  32'(data),  32'h1);
            check_eq("hold_state", 32'(state), 32'h9);
        end
        ready = 1'b1;
        tick();
        check_eq("release_valid", 32'(valid), 32'd0);
        check_eq("release_state", 32'(state), 32'h5);
        check_eq("release_cnt",   32'(cnt),   32'd2);
        ready = 1'b0;
        tick();
        check_eq("idle_valid", 32'(valid), 32'd0);

        // Seed load flushes a pending word
        en = 1'b1;
        tick();
        check_eq("pend_valid", 32'(valid), 32'd1);
        check_eq("pend_data",  32'(data),  32'h1);
        seed_valid = 1'b1; seed = 4'b0011;
        tick();
        seed_valid = 1'b0;
        check_eq("load_valid",  32'(valid),  32'd0);
        check_eq("load_state",  32'(state),  32'h3);
        check_eq("load_cnt",    32'(cnt),    32'd0);
        check_eq("load_lockup", 32'(lockup), 32'd0);
        tick();
        check_eq("load_next_valid", 32'(valid), 32'd1);
        check_eq("load_next_data",  32'(data),  32'h3);
        check_eq("load_next_cnt",   32'(cnt),   32'd0);

        // Zero seed is replaced by SEED and flagged with lockup_o
        seed_valid = 1'b1; seed = 4'b0000;
        tick();
        seed_valid = 1'b0;
        check_eq("zero_state",  32'(state),  32'hF);
        check_eq("zero_lockup", 32'(lockup), 32'd1);
        check_eq("zero_wrap",   32'(wrap),   32'd0);
        check_eq("zero_valid",  32'(valid),  32'd0);
        tick();
        check_eq("zero_lockup_end", 32'(lockup), 32'd0);
        check_eq("zero_next_valid", 32'(valid),  32'd1);
        check_eq("zero_next_state", 32'(state),  32'hF);

        // Seed load and fire in the same cycle: the load wins
        ready = 1'b1;
        tick();
        check_eq("pre_collide_state", 32'(state), 32'h9);
        check_eq("pre_collide_cnt",   32'(cnt),   32'd1);
        seed_valid = 1'b1; seed = 4'b0101;
        tick();
        seed_valid = 1'b0;
        check_eq("collide_state", 32'(state), 32'h5);
        check_eq("collide_cnt",   32'(cnt),   32'd0);
        check_eq("collide_valid", 32'(valid), 32'd0);
        check_eq("collide_wrap",  32'(wrap),  32'd0);
        // Wrap is now measured against the newly loaded seed 0101
        run_stream(4'h5, 8);

        // Asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_valid", 32'(valid), 32'd0);
        check_eq("async_state", 32'(state), 32'hF);
        check_eq("async_cnt",   32'(cnt),   32'd0);
        check_eq("async_wrap",  32'(wrap),  32'd0);
        tick();
        check_eq("async_hold_valid", 32'(valid), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check_eq("rerun_valid", 32'(valid), 32'd1);
        check_eq("rerun_data",  32'(data),  32'h3);
        check_eq("rerun_cnt",   32'(cnt),   32'd0);
        en = 1'b0; ready = 1'b0;

        // 8-bit sequences with ready tied high
        en8 = 1'b1;
        tick();
        check_eq("w8_first_valid_a", 32'(valid8a), 32'd1);
        check_eq("w8_first_valid_b", 32'(valid8b), 32'd1);
        exp_a = 8'h01; exp_b = 8'h01;
        wrap_at_a = -1; wrap_at_b = -1; period_b = -1;
        dups = 0; zeros = 0; distinct = 0; seen = '0;
        for (int k = 0; k < 256; k++) begin
            check_eq("w8_state_a", 32'(st8a), 32'(exp_a));
            check_eq("w8_state_b", 32'(st8b), 32'(exp_b));
            if (k > 0 && wrap8a && wrap_at_a < 0) wrap_at_a = k;
            if (k > 0 && wrap8b && wrap_at_b < 0) wrap_at_b = k;
            if (k < 255) begin
                if (seen[st8a]) dups++;
                else distinct++;
                seen[st8a] = 1'b1;
                if (st8a == 8'h00) zeros++;
            end
            if (period_b < 0 && model8(exp_b, 8'hB8) == 8'h01) period_b = k + 1;
            exp_a = model8(exp_a, 8'h1C);
            exp_b = model8(exp_b, 8'hB8);
            tick();
        end
        check_eq("w8_wrap_fires_a", 32'(wrap_at_a), 32'd255);
        check_eq("w8_dups_a",       32'(dups),      32'd0);
        check_eq("w8_zeros_a",      32'(zeros),     32'd0);
        check_eq("w8_distinct_a",   32'(distinct),  32'd255);
        check_eq("w8_wrap_fires_b", 32'(wrap_at_b), 32'(period_b));
        en8 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
